memory_arbiter: RTL

Shares one single-port unified memory between the phoeniX instruction and data memory interfaces.
- Accepts one request from each side, picks a winner, issues one memory access, and waits a fixed memory latency.
- Returns the read word with a one-cycle ready pulse to the granted side.
- Sits between the core top level and the system memory / MMIO bus.

---
 rtl/memory_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Arbitrates one shared single-port memory between the instruction and data interfaces.
// Optional MEMORY_ARBITER_ROUND_ROBIN_EN replaces data priority + starvation limit with round robin.
module memory_arbiter #(
   parameter int MEMORY_LATENCY   = 1,
   parameter int STARVATION_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instruction_memory_interface_enable,
   input  logic        instruction_memory_interface_state,
   input  logic [31:0] instruction_memory_interface_address,
   input  logic [3:0]  instruction_memory_interface_frame_mask,
   output logic [31:0] instruction_memory_interface_data,
   output logic        instruction_memory_interface_ready,
   input  logic        data_memory_interface_enable,
   input  logic        data_memory_interface_state,
   input  logic [31:0] data_memory_interface_address,
   input  logic [3:0]  data_memory_interface_frame_mask,
   input  logic [31:0] data_memory_interface_write_data,
   output logic [31:0] data_memory_interface_read_data,
   output logic        data_memory_interface_ready,
   output logic        memory_enable,
   output logic        memory_state,
   output logic [31:0] memory_address,
   output logic [3:0]  memory_frame_mask,
   output logic [31:0] memory_write_data,
   input  logic [31:0] memory_read_data,
   output logic        arbiter_busy
);

   localparam logic       OP_READ      = 1'b0;
   localparam logic [3:0] LATENCY_LOAD = 4'(MEMORY_LATENCY);
`ifndef MEMORY_ARBITER_ROUND_ROBIN_EN
   localparam logic [3:0] STARVE_MAX   = 4'(STARVATION_LIMIT);
`endif

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [3:0]  wait_cnt_r;
   logic        grant_data_r;
   logic        grant_data_s;
   logic        any_req_s;
   logic        grant_now_s;
   logic        last_wait_s;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
   logic        last_grant_data_r;
`else
   logic [3:0]  starve_cnt_r;
`endif

   // Winner selection; grant_data_s = 1 means the data side wins
   always_comb begin
      any_req_s    = instruction_memory_interface_enable | data_memory_interface_enable;
      grant_data_s = 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      if (instruction_memory_interface_enable && data_memory_interface_enable) begin
         grant_data_s = ~last_grant_data_r;
      end else begin
         grant_data_s = data_memory_interface_enable;
      end
`else
      if (data_memory_interface_enable &&
          !(instruction_memory_interface_enable && (starve_cnt_r == STARVE_MAX))) begin
         grant_data_s = 1'b1;
      end else begin
         grant_data_s = 1'b0;
      end
`endif
      grant_now_s = (state_r == ST_IDLE) && any_req_s;
      last_wait_s = (state_r == ST_WAIT) && (wait_cnt_r == 4'd1);
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_s = ST_ACCESS;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACCESS: state_s = ST_WAIT;
         ST_WAIT: begin
            if (wait_cnt_r == 4'd1) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State register and busy flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         arbiter_busy <= 1'b0;
      end else begin
         state_r      <= state_s;
         arbiter_busy <= (state_s != ST_IDLE);
      end
   end

   // Latch the winning request; these fields stay put until the next grant
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_data_r      <= 1'b0;
         memory_state      <= 1'b0;
         memory_address    <= 32'h0;
         memory_frame_mask <= 4'h0;
         memory_write_data <= 32'h0;
      end else if (grant_now_s) begin
         grant_data_r <= grant_data_s;
         if (grant_data_s) begin
            memory_state      <= data_memory_interface_state;
            memory_address    <= data_memory_interface_address;
            memory_frame_mask <= data_memory_interface_frame_mask;
            memory_write_data <= data_memory_interface_write_data;
         end else begin
            memory_state      <= instruction_memory_interface_state;
            memory_address    <= instruction_memory_interface_address;
            memory_frame_mask <= instruction_memory_interface_frame_mask;
            memory_write_data <= 32'h0;
         end
      end
   end

   // Access strobe (ACCESS cycle) and ready pulses (DONE cycle)
   always_ff @(posedge clk) begin
      if (reset) begin
         memory_enable                      <= 1'b0;
         instruction_memory_interface_ready <= 1'b0;
         data_memory_interface_ready        <= 1'b0;
      end else begin
         memory_enable                      <= grant_now_s;
         instruction_memory_interface_ready <= last_wait_s && !grant_data_r;
         data_memory_interface_ready        <= last_wait_s && grant_data_r;
      end
   end

   // Memory latency counter, loaded in ACCESS and counted down to 1 in WAIT
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_r <= 4'd0;
      end else if (state_r == ST_ACCESS) begin
         wait_cnt_r <= LATENCY_LOAD;
      end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd1)) begin
         wait_cnt_r <= wait_cnt_r - 4'd1;
      end
   end

   // Read word capture into the granted side; writes leave both registers alone
   always_ff @(posedge clk) begin
      if (reset) begin
         instruction_memory_interface_data <= 32'h0;
         data_memory_interface_read_data   <= 32'h0;
      end else if (last_wait_s && (memory_state == OP_READ)) begin
         if (grant_data_r) begin
            data_memory_interface_read_data <= memory_read_data;
         end else begin
            instruction_memory_interface_data <= memory_read_data;
         end
      end
   end

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
   // Remember the last winner so a simultaneous request goes to the other side
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_data_r <= 1'b0;
      end else if (grant_now_s) begin
         last_grant_data_r <= grant_data_s;
      end
   end
`else
   // Count data grants that overtook a waiting instruction request
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_r <= 4'd0;
      end else if (grant_now_s) begin
         if (!grant_data_s) begin
            starve_cnt_r <= 4'd0;
         end else if (instruction_memory_interface_enable) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
         end
      end
   end
`endif

endmodule
